riscv_div_ctrl: RTL

Iterative divide/remainder controller for the RI5CY EX stage. It sequences a 32-iteration restoring shift-subtract datapath for DIV, DIVU, REM and REMU, handles the RISC-V special cases without iterating, and plugs into the EX stall network alongside the ALU and multiplier. Its `ready_o` is ANDed into `ex_ready`/`ex_valid`, its `multicycle_o` goes to the ID stage, and its `result_o` is muxed into `regfile_alu_wdata_fw` when `enable_i` is high.

---
 rtl/riscv_div_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/riscv_div_ctrl.sv
// rtl/riscv_div_ctrl.sv - iterative restoring divide/remainder controller for the EX stage
module riscv_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [1:0]       operator_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    input  logic             ex_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ready_o,
    output logic             multicycle_o
);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             rem_q, rem_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic             signed_op, a_neg, b_neg, b_zero, ovf;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   trial, diff, r_step;
    logic             ge;
    logic [WIDTH-1:0] q_step, fin_q, fin_r;

    always_comb begin
        signed_op = ~operator_i[0];
        a_neg     = signed_op & op_a_i[WIDTH-1];
        b_neg     = signed_op & op_b_i[WIDTH-1];
        abs_a     = a_neg ? -op_a_i : op_a_i;
        abs_b     = b_neg ? -op_b_i : op_b_i;
        b_zero    = (op_b_i == '0);
        ovf       = signed_op && (op_a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b_i == '1);

        // One restoring step: shift next dividend bit into R, subtract if it fits.
        trial  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        diff   = trial - {1'b0, div_q};
        ge     = (trial >= {1'b0, div_q});
        r_step = ge ? diff : trial;
        q_step = {q_q[WIDTH-2:0], ge};
        fin_q  = neg_q ? -q_step : q_step;
        fin_r  = neg_q ? -r_step[WIDTH-1:0] : r_step[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        div_d   = div_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        res_d   = res_q;
        if (kill_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        rem_d = operator_i[1];
                        if (b_zero) begin
                            res_d   = operator_i[1] ? op_a_i : '1;
                            state_d = FINISH;
                        end else if (ovf) begin
                            res_d   = operator_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
                            state_d = FINISH;
                        end else begin
                            r_d     = '0;
                            q_d     = abs_a;
                            div_d   = abs_b;
                            cnt_d   = 5'd31;
                            neg_d   = operator_i[1] ? a_neg : (a_neg ^ b_neg);
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    r_d = r_step;
                    q_d = q_step;
                    if (cnt_q == 5'd0) begin
                        res_d   = rem_q ? fin_r : fin_q;
                        state_d = FINISH;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                FINISH: begin
                    if (ex_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            div_q   <= '0;
            rem_q   <= 1'b0;
            neg_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
        end
    end

    assign result_o     = res_q;
    assign ready_o      = ((state_q == IDLE) && !enable_i) || (state_q == FINISH);
    assign multicycle_o = (state_q != IDLE);

endmodule
